// File: rtl/priority_decode_pipe.sv
// -----------------------------------------------------------------------------
// priority_decode_pipe
//
// Regenerates a one-hot request vector from an encoded index plus an
// "any-request" flag, across a pipeline boundary. A 2-entry skid buffer sits
// between a valid/ready input and a valid/ready output, so s_ready is a
// registered signal and never depends combinationally on m_ready. Full
// throughput (one transfer per cycle), one cycle of latency when empty.
//
// The decode is done on the head entry at the output, so m_onehot/m_nz are a
// pure function of registered state (no s_* to m_* combinational path).
//
// Parameters:
//   IN_W      width of the encoded index (1..5); OUT_W = 2**IN_W is derived.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   s_valid   upstream word valid
//   s_ready   buffer can accept (registered, equals !full)
//   s_code    encoded index
//   s_nz      1 = some request present, 0 = encoder input was all-zero
//   m_valid   output word valid (occ != 0)
//   m_ready   downstream accepts
//   m_onehot  decoded vector: bit s_code set when nz=1, zero when nz=0
//   m_nz      nz flag of the head entry
//   occ       buffer occupancy 0..2
//
// Optional build macro:
//   PRIORITY_DECODE_HOLD_EN  when defined, m_onehot/m_nz hold the last popped
//                            word's values while m_valid=0 instead of zero.
//                            Only reset clears them. Handshake is unchanged.
// -----------------------------------------------------------------------------
module priority_decode_pipe #(
    parameter int IN_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_W-1:0]       s_code,
    input  logic                  s_nz,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [(2**IN_W)-1:0]  m_onehot,
    output logic                  m_nz,
    output logic [1:0]            occ
);

    localparam int OUT_W = 2 ** IN_W;

    // Buffer storage: two {code, nz} entries addressed by 1-bit pointers.
    logic [IN_W-1:0] code_q [2];
    logic            nz_q   [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      occ_q;
    logic            s_ready_q;

    logic            push;
    logic            pop;
    logic [1:0]      occ_next;

    logic [OUT_W-1:0] head_onehot;
    logic             head_nz;

    assign push    = s_valid & s_ready_q;
    assign pop     = m_valid & m_ready;
    assign m_valid = (occ_q != 2'd0);
    assign s_ready = s_ready_q;
    assign occ     = occ_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        occ_next = occ_q;
        case ({push, pop})
            2'b10:   occ_next = occ_q + 2'd1;
            2'b01:   occ_next = occ_q - 2'd1;
            default: occ_next = occ_q;
        endcase
    end

    // Pointers, occupancy and the registered ready flag. s_ready is derived
    // from the next occupancy so it is valid in the same cycle occ is.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            s_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            occ_q     <= occ_next;
            s_ready_q <= (occ_next != 2'd2);
        end
    end

    // Entry storage. A code pushed with nz=0 is a don't-care (possibly X), so
    // it is stored as zero; an X can then never reach the decoder.
    // NOTE: the two entries are reset because contents must be discarded on
    // reset and the idle outputs must read as zero; larger memories would
    // normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                code_q[i] <= '0;
                nz_q[i]   <= 1'b0;
            end
        end else if (push) begin
            code_q[wr_ptr_q] <= s_nz ? s_code : '0;
            nz_q[wr_ptr_q]   <= s_nz;
        end
    end

    // Decode of the head entry; compare per bit instead of shifting so a
    // cleared nz forces the whole vector to zero.
    always_comb begin
        head_nz     = nz_q[rd_ptr_q];
        head_onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            head_onehot[i] = head_nz && (code_q[rd_ptr_q] == IN_W'(i));
        end
    end

`ifdef PRIORITY_DECODE_HOLD_EN
    // Sticky last grant: captured on every pop, shown while the buffer is idle.
    logic [OUT_W-1:0] last_onehot_q;
    logic             last_nz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_onehot_q <= '0;
            last_nz_q     <= 1'b0;
        end else if (pop) begin
            last_onehot_q <= head_onehot;
            last_nz_q     <= head_nz;
        end
    end

    assign m_onehot = m_valid ? head_onehot : last_onehot_q;
    assign m_nz     = m_valid ? head_nz     : last_nz_q;
`else
    assign m_onehot = m_valid ? head_onehot : '0;
    assign m_nz     = m_valid & head_nz;
`endif

endmodule

// File: tb/tb_priority_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_priority_decode_pipe
//
// Directed bench for priority_decode_pipe (IN_W=2, OUT_W=4). Inputs change and
// outputs are sampled 1 time unit after the rising edge. Idle-output
// expectations follow the PRIORITY_DECODE_HOLD_EN build selection.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_priority_decode_pipe;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_code;
    logic       s_nz;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_onehot;
    logic       m_nz;
    logic [1:0] occ;

    int total = 0;
    int bad   = 0;

    priority_decode_pipe #(.IN_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_code   (s_code),
        .s_nz     (s_nz),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_onehot (m_onehot),
        .m_nz     (m_nz),
        .occ      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected idle outputs given the last popped word.
    function automatic logic [3:0] idle_oh(input logic [3:0] last_oh);
`ifdef PRIORITY_DECODE_HOLD_EN
        return last_oh;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic logic idle_nz(input logic last_nz);
`ifdef PRIORITY_DECODE_HOLD_EN
        return last_nz;
`else
        return 1'b0;
`endif
    endfunction

    logic [3:0] stream_exp [4];

    initial begin
        stream_exp[0] = 4'b0001;
        stream_exp[1] = 4'b0010;
        stream_exp[2] = 4'b0100;
        stream_exp[3] = 4'b1000;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_code  = 2'b00;
        s_nz    = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset then idle.
        for (int i = 0; i < 10; i++) begin
            check("idle_occ",     occ,      2'd0);
            check("idle_s_ready", s_ready,  1'b1);
            check("idle_m_valid", m_valid,  1'b0);
            check("idle_onehot",  m_onehot, 4'b0000);
            check("idle_nz",      m_nz,     1'b0);
            tick();
        end

        // Single push, code 2.
        s_valid = 1'b1; s_code = 2'b10; s_nz = 1'b1;
        tick();
        s_valid = 1'b0;
        check("single_valid",  m_valid,  1'b1);
        check("single_onehot", m_onehot, 4'b0100);
        check("single_nz",     m_nz,     1'b1);
        check("single_occ",    occ,      2'd1);
        tick();
        check("single_drain_valid",  m_valid,  1'b0);
        check("single_drain_onehot", m_onehot, idle_oh(4'b0100));
        check("single_drain_nz",     m_nz,     idle_nz(1'b1));

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_code = 2'(i); s_nz = 1'b1;
            tick();
            check("stream_onehot",  m_onehot, stream_exp[i]);
            check("stream_valid",   m_valid,  1'b1);
            check("stream_s_ready", s_ready,  1'b1);
            check("stream_occ",     occ,      2'd1);
        end
        s_valid = 1'b0;
        tick();
        check("stream_drain_valid",  m_valid,  1'b0);
        check("stream_drain_onehot", m_onehot, idle_oh(4'b1000));

        // Fill with m_ready low, hold a third word, then release.
        m_ready = 1'b0;
        s_valid = 1'b1; s_code = 2'd3; s_nz = 1'b1;
        tick();
        check("fill1_occ",     occ,     2'd1);
        check("fill1_s_ready", s_ready, 1'b1);
        s_code = 2'd1;
        tick();
        check("fill2_occ",     occ,      2'd2);
        check("fill2_s_ready", s_ready,  1'b0);
        check("fill2_onehot",  m_onehot, 4'b1000);
        s_code = 2'd0;
        tick();
        check("full_hold_occ",     occ,      2'd2);
        check("full_hold_s_ready", s_ready,  1'b0);
        check("full_hold_onehot",  m_onehot, 4'b1000);
        m_ready = 1'b1;
        tick();
        check("rel1_onehot",  m_onehot, 4'b0010);
        check("rel1_occ",     occ,      2'd1);
        check("rel1_s_ready", s_ready,  1'b1);
        tick();
        s_valid = 1'b0;
        check("rel2_onehot", m_onehot, 4'b0001);
        check("rel2_occ",    occ,      2'd1);
        tick();
        check("rel3_valid", m_valid, 1'b0);
        check("rel3_occ",   occ,     2'd0);
        check("rel3_onehot", m_onehot, idle_oh(4'b0001));

        // nz=0 with an unknown code: zero vector, no X.
        s_valid = 1'b1; s_code = 2'bxx; s_nz = 1'b0;
        tick();
        s_valid = 1'b0; s_code = 2'b00;
        check("nz0_valid",  m_valid,  1'b1);
        check("nz0_onehot", m_onehot, 4'b0000);
        check("nz0_nz",     m_nz,     1'b0);
        tick();
        check("nz0_drain_valid",  m_valid,  1'b0);
        check("nz0_drain_onehot", m_onehot, 4'b0000);

        // Reset asserted mid-cycle while full.
        m_ready = 1'b0;
        s_valid = 1'b1; s_code = 2'd2; s_nz = 1'b1;
        tick();
        s_code = 2'd3;
        tick();
        s_valid = 1'b0;
        check("pre_rst_occ", occ, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_occ",     occ,      2'd0);
        check("rst_m_valid", m_valid,  1'b0);
        check("rst_s_ready", s_ready,  1'b1);
        check("rst_onehot",  m_onehot, 4'b0000);
        check("rst_nz",      m_nz,     1'b0);
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();
        check("post_rst_occ", occ, 2'd0);

        // Pop code 1, then idle: held value in the sticky build, zero otherwise.
        s_valid = 1'b1; s_code = 2'd1; s_nz = 1'b1;
        tick();
        s_valid = 1'b0;
        check("last_onehot", m_onehot, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("last_idle_valid",  m_valid,  1'b0);
            check("last_idle_onehot", m_onehot, idle_oh(4'b0010));
            check("last_idle_nz",     m_nz,     idle_nz(1'b1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
